sgd_adder_tree_sched: RTL and testbench

Round-robin scheduler that shares one sgd_adder_tree among NUM_REQ requesting engines.
- Grants one request per cycle and registers the winner's vector onto the tree input.
- Records the winner's index in a tag FIFO.
- Routes each tree result back to the requester that issued it.
- Sits between the per-bank gradient engines and the single shared adder tree.

---
 rtl/sgd_tree_pkg.sv | 12 +
 rtl/sgd_tag_fifo.sv | 56 +++++
 rtl/sgd_adder_tree_sched.sv | 117 +++++++++++
 tb/tb_sgd_adder_tree_sched.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sgd_tree_pkg.sv
// rtl/sgd_tree_pkg.sv - shared data type, width constant and tag-width helper for the adder-tree scheduler
package sgd_tree_pkg;

  localparam int DATA_WIDTH = 32;

  typedef logic signed [DATA_WIDTH-1:0] sgd_data_t;

  function automatic int tag_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/sgd_tag_fifo.sv
// rtl/sgd_tag_fifo.sv - synchronous FIFO holding requester tags of in-flight tree operations
module sgd_tag_fifo #(
  parameter  int TAG_W = 2,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output logic [TAG_W-1:0] pop_tag,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             underflow
);

  logic [TAG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign underflow = pop & empty;
  assign pop_tag   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_tag;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sgd_adder_tree_sched.sv
// rtl/sgd_adder_tree_sched.sv - round-robin sharing of one adder tree among NUM_REQ engines (option: SGD_TREE_SCHED_STATS_EN)
module sgd_adder_tree_sched
  import sgd_tree_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int NUM_INPUTS     = 9,
  parameter int DATA_WIDTH     = sgd_tree_pkg::DATA_WIDTH,
  parameter int TAG_FIFO_DEPTH = 8
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                sched_en,
  input  logic signed [NUM_REQ-1:0][NUM_INPUTS-1:0][DATA_WIDTH-1:0] req_data,
  input  logic        [NUM_REQ-1:0]                           req_valid,
  output logic        [NUM_REQ-1:0]                           req_ready,
  output logic signed [NUM_INPUTS-1:0][DATA_WIDTH-1:0]        tree_v_input,
  output logic                                                tree_v_input_valid,
  input  logic signed [DATA_WIDTH-1:0]                        tree_v_output,
  input  logic                                                tree_v_output_valid,
  output logic signed [DATA_WIDTH-1:0]                        resp_data,
  output logic        [NUM_REQ-1:0]                           resp_valid,
  output logic                                                idle,
  output logic                                                err_orphan,
  output logic        [NUM_REQ-1:0][31:0]                     stat_grant_cnt
);

  localparam int TAG_W = tag_width(NUM_REQ);
  localparam int CNT_W = $clog2(TAG_FIFO_DEPTH) + 1;

  logic [TAG_W-1:0] rr_ptr;
  logic [TAG_W-1:0] win_idx;
  logic             win_found;
  logic [TAG_W-1:0] pop_tag;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_underflow;

  // A full FIFO blocks issue even when a pop lands in the same cycle.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    if (sched_en && !fifo_full) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!win_found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
          win_found = 1'b1;
          win_idx   = TAG_W'((int'(rr_ptr) + k) % NUM_REQ);
        end
      end
    end
  end

  assign req_ready = win_found ? (NUM_REQ'(1) << win_idx) : '0;
  assign idle      = fifo_empty & ~tree_v_input_valid;

  sgd_tag_fifo #(
    .TAG_W (TAG_W),
    .DEPTH (TAG_FIFO_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (win_found),
    .push_tag  (win_idx),
    .pop       (tree_v_output_valid),
    .pop_tag   (pop_tag),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .underflow (fifo_underflow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr             <= '0;
      tree_v_input       <= '0;
      tree_v_input_valid <= 1'b0;
      resp_data          <= '0;
      resp_valid         <= '0;
      err_orphan         <= 1'b0;
    end else begin
      tree_v_input_valid <= win_found;
      if (win_found) begin
        tree_v_input <= req_data[win_idx];
        rr_ptr       <= (win_idx == TAG_W'(NUM_REQ - 1)) ? '0 : win_idx + TAG_W'(1);
      end
      resp_valid <= '0;
      if (tree_v_output_valid) begin
        // A result with no owner is flagged and dropped.
        if (fifo_underflow) begin
          err_orphan <= 1'b1;
        end else begin
          resp_data  <= tree_v_output;
          resp_valid <= NUM_REQ'(1) << pop_tag;
        end
      end
    end
  end

`ifdef SGD_TREE_SCHED_STATS_EN
  logic [NUM_REQ-1:0][31:0] grant_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i]) grant_cnt[i] <= grant_cnt[i] + 32'd1;
      end
    end
  end

  assign stat_grant_cnt = grant_cnt;
`else
  assign stat_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_sgd_adder_tree_sched.sv
// tb/tb_sgd_adder_tree_sched.sv - directed scoreboard bench with a latency-programmable adder-tree model
module tb_sgd_adder_tree_sched;
  import sgd_tree_pkg::*;

  localparam int NR = 4;
  localparam int NI = 9;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       sched_en;
  sgd_data_t [NR-1:0][NI-1:0] req_data;
  logic      [NR-1:0]         req_valid;
  logic      [NR-1:0]         req_ready;
  sgd_data_t [NI-1:0]         tree_v_input;
  logic                       tree_v_input_valid;
  sgd_data_t                  tree_v_output;
  logic                       tree_v_output_valid;
  sgd_data_t                  resp_data;
  logic      [NR-1:0]         resp_valid;
  logic                       idle;
  logic                       err_orphan;
  logic      [NR-1:0][31:0]   stat_grant_cnt;

  logic      model_v = 1'b0;
  sgd_data_t model_d = '0;
  logic      inj;
  sgd_data_t inj_d;

  assign tree_v_output_valid = model_v | inj;
  assign tree_v_output       = inj ? inj_d : model_d;

  int n_vec = 0;
  int n_err = 0;
  int n_resp = 0;
  int cyc = 0;
  int tree_lat = 4;

  typedef struct {int due; sgd_data_t sum;} tr_t;
  typedef struct {int tag; sgd_data_t sum; int due;} exp_t;
  tr_t  tq[$];
  exp_t sb[$];

  sgd_adder_tree_sched #(
    .NUM_REQ        (NR),
    .NUM_INPUTS     (NI),
    .DATA_WIDTH     (32),
    .TAG_FIFO_DEPTH (8)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .sched_en            (sched_en),
    .req_data            (req_data),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .tree_v_input        (tree_v_input),
    .tree_v_input_valid  (tree_v_input_valid),
    .tree_v_output       (tree_v_output),
    .tree_v_output_valid (tree_v_output_valid),
    .resp_data           (resp_data),
    .resp_valid          (resp_valid),
    .idle                (idle),
    .err_orphan          (err_orphan),
    .stat_grant_cnt      (stat_grant_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Tree model: sums the lanes and returns the result tree_lat cycles after the input cycle.
  always @(negedge clk) begin
    sgd_data_t ts;
    if (!rst_n) begin
      tq.delete();
    end else if (tree_v_input_valid) begin
      ts = '0;
      for (int i = 0; i < NI; i++) ts = ts + tree_v_input[i];
      tq.push_back('{cyc + tree_lat, ts});
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    model_v = 1'b0;
    if (tq.size() > 0 && tq[0].due == cyc) begin
      model_v = 1'b1;
      model_d = tq[0].sum;
      void'(tq.pop_front());
    end
  end

  // Scoreboard: push on each observed transfer, pop on each response.
  always @(negedge clk) begin
    exp_t      e;
    sgd_data_t s;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (resp_valid != '0) begin
        if (sb.size() == 0) begin
          check("resp_unexpected", 64'(resp_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("resp_owner", 64'(resp_valid), 64'(4'b1 << e.tag));
          check("resp_data", 64'(resp_data), 64'(e.sum));
          check("resp_cycle", 64'(cyc), 64'(e.due));
          n_resp++;
        end
      end
      for (int k = 0; k < NR; k++) begin
        if (req_valid[k] && req_ready[k]) begin
          s = '0;
          for (int i = 0; i < NI; i++) s = s + req_data[k][i];
          sb.push_back('{k, s, cyc + 2 + tree_lat});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (!(idle && sb.size() == 0 && tq.size() == 0 && !model_v) && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_drain_timeout"}, 64'(n < 200), 64'd1);
  endtask

  initial begin
    int t0, start, pop_cyc, ninth, ngr, r0, n;
    rst_n     = 1'b0;
    sched_en  = 1'b0;
    req_valid = '0;
    req_data  = '0;
    inj       = 1'b0;
    inj_d     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_tvi_valid", 64'(tree_v_input_valid), 64'd0);
    check("rst_tvi_lane0", 64'(tree_v_input[0]), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_data", 64'(resp_data), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_err_orphan", 64'(err_orphan), 64'd0);
    check("rst_stat0", 64'(stat_grant_cnt[0]), 64'd0);
    tick();
    rst_n    = 1'b1;
    sched_en = 1'b1;

    // Single request, L=4
    tree_lat = 4;
    for (int i = 0; i < NI; i++) req_data[0][i] = 32'(i);
    req_valid = 4'b0001;
    t0 = cyc;
    @(negedge clk);
    check("t1_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("t1_tvi_valid", 64'(tree_v_input_valid), 64'd1);
    for (int i = 0; i < NI; i++) check("t1_tvi_lane", 64'(tree_v_input[i]), 64'(i));
    tick();
    @(negedge clk);
    check("t1_tvi_valid_drop", 64'(tree_v_input_valid), 64'd0);
    check("t1_tvi_hold", 64'(tree_v_input[8]), 64'd8);
    n = 0;
    while (resp_valid == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t1_resp_seen", 64'(n < 20), 64'd1);
    check("t1_resp_data", 64'(resp_data), 64'd36);
    check("t1_resp_valid", 64'(resp_valid), 64'h1);
    check("t1_resp_cycle", 64'(cyc), 64'(t0 + 6));
    drain("t1");

    // All four continuously valid: round-robin 0,1,2,3,0...
    do_reset();
    for (int k = 0; k < NR; k++)
      for (int i = 0; i < NI; i++) req_data[k][i] = 32'(k + 1);
    r0 = n_resp;
    req_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("t2_rr_grant", 64'(req_ready), 64'(4'b1 << (c % 4)));
      tick();
    end
    req_valid = '0;
    drain("t2");
    check("t2_resp_count", 64'(n_resp - r0), 64'd8);
`ifdef SGD_TREE_SCHED_STATS_EN
    for (int k = 0; k < NR; k++) check("t2_stat", 64'(stat_grant_cnt[k]), 64'd2);
`else
    for (int k = 0; k < NR; k++) check("t2_stat_tied", 64'(stat_grant_cnt[k]), 64'd0);
`endif

    // FIFO full with L=12
    do_reset();
    tree_lat = 12;
    for (int i = 0; i < NI; i++) req_data[0][i] = 32'(100 + i);
    req_valid = 4'b0001;
    start   = cyc;
    pop_cyc = -1;
    ninth   = -1;
    ngr     = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tree_v_output_valid && pop_cyc < 0) pop_cyc = cyc;
      if (req_ready[0]) begin
        ngr++;
        if (ngr == 9) ninth = cyc;
      end
      if (c == 7)  check("t3_eight_grants", 64'(ngr), 64'd8);
      if (c == 13) check("t3_blocked_full", 64'(ngr), 64'd8);
      tick();
    end
    check("t3_ninth_cycle", 64'(ninth), 64'(start + 14));
    check("t3_ninth_after_pop", 64'(ninth), 64'(pop_cyc + 1));
    req_valid = '0;
    drain("t3");
    tree_lat = 4;

    // sched_en drop after two grants
    do_reset();
    r0 = n_resp;
    req_valid = 4'b0011;
    @(negedge clk);
    check("t4_grant0", 64'(req_ready), 64'h1);
    tick();
    @(negedge clk);
    check("t4_grant1", 64'(req_ready), 64'h2);
    tick();
    sched_en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t4_no_grant", 64'(req_ready), 64'd0);
      tick();
    end
    req_valid = '0;
    drain("t4");
    check("t4_resp_count", 64'(n_resp - r0), 64'd2);
    check("t4_idle", 64'(idle), 64'd1);
    sched_en = 1'b1;

    // Orphan result
    inj   = 1'b1;
    inj_d = 32'sd123;
    tick();
    inj = 1'b0;
    @(negedge clk);
    check("t5_err_set", 64'(err_orphan), 64'd1);
    check("t5_no_resp", 64'(resp_valid), 64'd0);
    repeat (3) tick();
    check("t5_err_sticky", 64'(err_orphan), 64'd1);
    do_reset();
    check("t5_err_cleared", 64'(err_orphan), 64'd0);

    // Reset with three ops in flight
    for (int k = 0; k < NR; k++)
      for (int i = 0; i < NI; i++) req_data[k][i] = 32'(k + 1);
    req_valid = 4'hF;
    tick();
    tick();
    tick();
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    check("t6_idle", 64'(idle), 64'd1);
    check("t6_tvi_valid", 64'(tree_v_input_valid), 64'd0);
    check("t6_resp_valid", 64'(resp_valid), 64'd0);
    check("t6_req_ready", 64'(req_ready), 64'd0);
    check("t6_err", 64'(err_orphan), 64'd0);
    for (int k = 0; k < NR; k++) check("t6_stat_zero", 64'(stat_grant_cnt[k]), 64'd0);
    tick();
    rst_n = 1'b1;
    req_valid = 4'b0100;
    @(negedge clk);
    check("t6_grant_after_rst", 64'(req_ready), 64'h4);
    tick();
    req_valid = '0;
    tick();
`ifdef SGD_TREE_SCHED_STATS_EN
    check("t6_stat2", 64'(stat_grant_cnt[2]), 64'd1);
    check("t6_stat0", 64'(stat_grant_cnt[0]), 64'd0);
`else
    check("t6_stat2_tied", 64'(stat_grant_cnt[2]), 64'd0);
`endif
    drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
